// File: rtl/bin2bcd_seq.sv
// Sequential two's-complement to sign + BCD converter (double-dabble, one bit per clock); BIN2BCD_SIGNED_EN enables signed input.
// Latency: done pulses WIDTH cycles after the accepting edge; one result per WIDTH+1 cycles back-to-back.
// Backpressure: none; start is only accepted in IDLE/DONE and is dropped while busy.
module bin2bcd_seq #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic             sign,
   output logic [3:0]       bcd [DIGITS-1:0],
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int AW = DIGITS * 4;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept, last;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mag, mag_nxt, mag_load;
   logic [AW-1:0]    acc, acc_adj, acc_nxt, bcd_q;
   logic             shift_out, ovf_sticky, ovf_final, sign_lat, sign_in;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      last      = (cnt == CW'(WIDTH - 1));
      case (state)
         IDLE: begin
            accept = start;
            if (start) state_nxt = CONV;
         end
         CONV: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            accept    = start;
            state_nxt = start ? CONV : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Magnitude is held unsigned so the most negative input negates to itself correctly.
   always_comb begin
`ifdef BIN2BCD_SIGNED_EN
      sign_in  = value[WIDTH-1];
      mag_load = sign_in ? (~value + 1'b1) : value;
`else
      sign_in  = 1'b0;
      mag_load = value;
`endif
   end

   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
      {shift_out, acc_nxt, mag_nxt} = {acc_adj, mag, 1'b0};
      ovf_final = ovf_sticky | shift_out;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mag        <= '0;
         acc        <= '0;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
         sign_lat   <= 1'b0;
         bcd_q      <= '0;
         sign       <= 1'b0;
         overflow   <= 1'b0;
      end else if (accept) begin
         mag        <= mag_load;
         acc        <= '0;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
         sign_lat   <= sign_in;
      end else if (state == CONV) begin
         mag        <= mag_nxt;
         acc        <= acc_nxt;
         cnt        <= cnt + 1'b1;
         ovf_sticky <= ovf_final;
         // Result registers only change on the final shift, never showing partial values.
         if (last) begin
            overflow <= ovf_final;
            if (ovf_final) begin
               bcd_q <= {DIGITS{4'hE}};
               sign  <= sign_lat;
            end else begin
               bcd_q <= acc_nxt;
               sign  <= sign_lat & (|acc_nxt);
            end
         end
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_bcd
      assign bcd[g] = bcd_q[4*g +: 4];
   end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that feeds `bcd2disp`. It converts a WIDTH-bit two's-complement value to a sign bit plus DIGITS BCD digits using a shift-add-3 (double-dabble) loop, one bit per clock. It sits between the arithmetic/result registers and the display formatter. Its `sign` and `bcd` outputs connect directly to `bcd2disp` `sign`/`bcd` with the same WIDTH/DIGITS.

## Interface
- WIDTH, 32, input value width in bits.
- DIGITS, 10, BCD digits produced; digit 0 is least significant.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion of `value`; sampled only when accepting.
- value  input  WIDTH  operand: two's complement, or unsigned when signed support is compiled out.
- busy  output  1  high while in CONV.
- done  output  1  one-cycle pulse when a result is written to outputs.
- sign  output  1  result sign (1 = negative).
- bcd  output  [3:0] x DIGITS  result digits, unpacked array `[3:0] bcd [DIGITS-1:0]`.
- overflow  output  1  magnitude did not fit in DIGITS digits.

## Operation
- FSM states:
  - IDLE: accepting. `start` → CONV.
  - CONV: shifting; `start` is ignored.
  - DONE: accepting. `start` → CONV, else → IDLE.
- Accept (start=1 in IDLE or DONE):
  - Latch the sign as `value[WIDTH-1]` (signed build).
  - Load magnitude = |value| into a WIDTH-bit shift register, treating the result as unsigned. The most negative value 2^(WIDTH-1) is therefore represented correctly.
  - Clear the DIGITS×4 BCD accumulator, clear the internal overflow sticky bit, and clear the bit counter.
- Each CONV cycle:
  - For every accumulator digit ≥5, add 3.
  - Shift {accumulator, magnitude} left by 1.
  - If the bit shifted out of the top digit is 1, set the overflow sticky bit.
  - Increment the counter.
- After the WIDTH-th shift, go to DONE and register the outputs:
  - `bcd` = accumulator and `sign` = latched sign, unless overflow.
  - On overflow: every `bcd` digit = 4'hE (rendered as asterisks downstream), `overflow`=1, `sign` = latched sign.
- Zero result: sign forced to 0 (no "-0").
- Outputs `sign`/`bcd`/`overflow` hold their last result until the next DONE entry. They never show partial values.
- `value` only needs to be stable in the accepting cycle.

## Timing
- Reset:
  - State IDLE, busy=0, done=0, sign=0, overflow=0, all `bcd` digits 4'h0.
  - Counter and accumulators cleared.
  - Reset takes priority over start.
- Latency:
  - `start` sampled at edge E0. Shifts occur at E1..E_WIDTH.
  - done=1 and new outputs are valid in the cycle following E_WIDTH, i.e. WIDTH cycles after E0.
- busy: high from the cycle after E0 through the cycle ending at E_WIDTH.
- done: exactly one cycle per accepted conversion.
- Throughput: back-to-back starts give one result per WIDTH+1 cycles. A start held high continuously is re-accepted in each DONE cycle.
- start=1 during CONV is dropped, not queued.
- Reset mid-CONV aborts the conversion: no done pulse, and outputs return to reset values.

## Configuration
- BIN2BCD_SIGNED_EN:
  - Defined: `value` is two's complement; sign extraction and magnitude negation are present.
  - Undefined: `value` is unsigned, no negation logic, `sign` is tied to 0, and the full WIDTH bits are magnitude (e.g. 32'hFFFFFFFF → 4294967295).

## Test plan
- Zero, signed build: reset, then start with value=0 → done exactly 32 cycles after the start edge; sign=0, all digits 0, overflow=0.
- Negative value: value=-12345 (32'hFFFFCFC7) → sign=1; bcd[4..0]=1,2,3,4,5; higher digits 0.
- Most negative: value=32'h80000000 → sign=1; bcd[9..0]=2,1,4,7,4,8,3,6,4,8; overflow=0.
- Overflow: WIDTH=16, DIGITS=3, value=1000 → overflow=1, all digits 4'hE. Then value=999 → overflow=0, digits 9,9,9.
- Start during busy: pulse start again at cycle 5 of a conversion with a different value → ignored; only one done pulse, carrying the original result. Holding start high gives a done every 33 cycles.
- Reset mid-conversion: assert reset at cycle 10 of CONV → next cycle busy=0, outputs at reset values, no done pulse; a fresh start then completes normally.
